fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, is the instruction buffer depth (power of two, >= 2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 imem_req  output  1  one-cycle fetch request pulse.
REQ-006 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-007 imem_ack  input  1  response strobe for the single outstanding request.
REQ-008 imem_rdata  input  32  instruction word, valid while imem_ack=1.
REQ-009 stall  input  1  decode cannot accept the presented instruction this cycle.
REQ-010 redirect  input  1  branch/jump taken; discard all fetched and in-flight work.
REQ-011 redirect_pc  input  32  new fetch address, qualified by redirect.
REQ-012 if_valid  output  1  if_instruction/if_pc hold a valid entry.
REQ-013 if_instruction  output  instruction_type  instruction word for the decode stage and imm_gen.
REQ-014 if_pc  output  32  address of if_instruction.

Function
REQ-015 The fetch FSM SHALL have states IDLE, WAIT and DROP.
REQ-016 In IDLE, imem_req=1 iff count < FIFO_DEPTH and redirect=0; imem_addr=fetch_pc; next state WAIT.
REQ-017 At most one request SHALL be outstanding; imem_req=0 in WAIT and DROP.
REQ-018 imem_ack SHALL be ignored in IDLE, including in the cycle of the request.
REQ-019 In WAIT, on imem_ack without redirect: push {fetch_pc, imem_rdata}; fetch_pc += 4 (mod 2^32); next state IDLE.
REQ-020 redirect SHALL, in the same edge: empty the FIFO; set fetch_pc = {redirect_pc[31:2], 2'b00}; take priority over stall, push and pop.
REQ-021 Redirect in WAIT without imem_ack SHALL go to DROP; redirect with imem_ack SHALL discard the data and go to IDLE.
REQ-022 In DROP, imem_ack SHALL discard data and go to IDLE; a further redirect in DROP only updates fetch_pc.
REQ-023 if_valid SHALL be (count != 0) and not redirect; if_instruction/if_pc SHALL show the FIFO head.
REQ-024 Pop SHALL occur on (if_valid and not stall); stall holds the head outputs stable.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-026 Push into a full FIFO cannot occur (REQ-016); read/write pointers wrap modulo FIFO_DEPTH.
REQ-027 Latency: ack at edge N makes if_valid=1 in cycle N+1 (registered FIFO, no bypass).

Reset
REQ-028 reset SHALL force state IDLE, fetch_pc=RESET_PC, count=0, pointers=0 and override every other input.
REQ-029 During reset, imem_req=0, if_valid=0, if_instruction=0 and if_pc=0.
REQ-030 A request outstanding at reset SHALL be abandoned; a later imem_ack SHALL be ignored because the FSM is in IDLE.
REQ-031 The first request SHALL be issued in the first cycle after reset deasserts, at RESET_PC.

Structure
REQ-032 instruction_type and a fetch-state enum SHALL live in package common; no new package SHALL be added.
REQ-033 The buffer SHALL be a sub-module fetch_fifo (parameterised depth, push/pop/flush, count, head data), holding {pc, instruction}.
REQ-034 All outputs except imem_req and if_valid SHALL be driven directly from registers.

Verification
REQ-035 Reset, ack 1 cycle after every request, stall=0 -> imem_addr 0x0, 0x4, 0x8; if_pc sequence 0x0, 0x4, 0x8, each with matching rdata.
REQ-036 stall=1 held for 10 cycles -> at most 2 entries buffered; imem_req stays 0 once full; if_pc stays constant; after release, order is preserved with no loss.
REQ-037 Redirect to 0x103 while in WAIT, ack 3 cycles later -> acked data discarded; next imem_addr 0x100; if_valid=0 in the redirect cycle.
REQ-038 redirect and imem_ack in the same cycle, with stall=1 -> FIFO empty, no push, next request to redirect_pc.
REQ-039 reset asserted in WAIT, stray ack in the first post-reset cycle -> ignored; first request at RESET_PC.
REQ-040 fetch_pc=0xFFFF_FFFC acked -> next imem_addr 0x0000_0000.

Source files
------------

// File: rtl/common_pkg.sv
// Shared fetch-path types: the instruction word, fetch FSM states and the buffered entry.
package common;

    typedef logic [31:0] instruction_type;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]     pc;
        instruction_type instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding {pc, instruction}; flush empties it in one edge.
module fetch_fifo
    import common::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // Entries are cleared on reset so the head reads as zero while reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding memory request, redirect handling, buffered output to decode.
//   state      | meaning
//   FETCH_IDLE | may issue a request when the buffer has room
//   FETCH_WAIT | request outstanding, response will be buffered
//   FETCH_DROP | request outstanding, response will be discarded
module fetch_stage
    import common::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    fetch_stage_if.master   imem,
    input  logic            stall,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    output logic            if_valid,
    output instruction_type if_instruction,
    output logic [31:0]     if_pc
);
    localparam int             CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e  state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic          req;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    fetch_entry_t  head;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req          = 1'b0;
        push         = 1'b0;
        unique case (state)
            FETCH_IDLE: begin
                if (!redirect && (count < DEPTH_C)) begin
                    req       = 1'b1;
                    state_nxt = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem.imem_ack) begin
                    state_nxt = FETCH_IDLE;
                    if (!redirect) begin
                        push         = 1'b1;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                    end
                end else if (redirect) begin
                    state_nxt = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (imem.imem_ack) begin
                    state_nxt = FETCH_IDLE;
                end
            end
            default: state_nxt = FETCH_IDLE;
        endcase
        if (redirect) begin
            fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({fetch_pc, imem.imem_rdata}),
        .count (count),
        .head  (head)
    );

    // Redirect hides the head in the same cycle so decode never consumes a squashed entry.
    assign if_valid       = (count != '0) && !redirect && !reset;
    assign pop            = if_valid && !stall;
    assign imem.imem_req  = req && !reset;
    assign imem.imem_addr = fetch_pc;
    assign if_instruction = head.instruction;
    assign if_pc          = head.pc;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed and random checks of fetch_stage against a queue-based model of the fetch rules.
module tb_fetch_stage;
    import common::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            if_valid;
    instruction_type if_instruction;
    logic [31:0]     if_pc;

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (imem),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_busy;
    bit          m_drop;

    int total = 0;
    int bad   = 0;

    bit pend;
    int lat;
    int next_lat;
    bit last_req;
    bit found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit ack, input logic [31:0] rdata,
                        input bit stl, input bit rd, input logic [31:0] rpc);
        bit req_e;
        bit val_e;
        @(negedge clk);
        reset           = rst;
        imem.imem_ack   = ack;
        imem.imem_rdata = rdata;
        stall           = stl;
        redirect        = rd;
        redirect_pc     = rpc;
        #1;
        req_e = !rst && !m_busy && (mq.size() < DEPTH) && !rd;
        val_e = !rst && (mq.size() != 0) && !rd;
        chk("imem_req", {31'b0, imem.imem_req}, {31'b0, req_e});
        if (req_e) chk("imem_addr", imem.imem_addr, m_pc);
        chk("if_valid", {31'b0, if_valid}, {31'b0, val_e});
        if (val_e) begin
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_instruction", if_instruction, mq[0].ins);
        end
        last_req = imem.imem_req;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_pc   = RPC;
            m_busy = 1'b0;
            m_drop = 1'b0;
        end else begin
            if (val_e && !stl) void'(mq.pop_front());
            if (m_busy && ack) begin
                if (!m_drop && !rd) begin
                    mq.push_back('{m_pc, rdata});
                    m_pc = m_pc + 32'd4;
                end
                m_busy = 1'b0;
                m_drop = 1'b0;
            end else if (m_busy && rd) begin
                m_drop = 1'b1;
            end
            if (req_e) m_busy = 1'b1;
            if (rd) begin
                mq.delete();
                m_pc = {rpc[31:2], 2'b00};
            end
        end
    endtask

    // Memory responder: acks the observed request after next_lat idle cycles.
    task automatic mem_cycle(input bit rst, input bit stl, input bit rd, input logic [31:0] rpc);
        bit          ack;
        logic [31:0] d;
        ack = pend && (lat == 0);
        d   = $urandom;
        if (pend && lat > 0) lat--;
        step(rst, ack, d, stl, rd, rpc);
        if (ack) pend = 1'b0;
        if (last_req) begin
            pend = 1'b1;
            lat  = next_lat;
        end
    endtask

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = '0;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = '0;
        m_pc            = RPC;
        pend            = 1'b0;
        lat             = 0;
        next_lat        = 0;

        repeat (3) mem_cycle(1, 0, 0, 0);
        #1;
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instruction", if_instruction, 32'h0);

        // back-to-back single-cycle acks
        next_lat = 0;
        repeat (8) mem_cycle(0, 0, 0, 0);

        // long stall fills the buffer, then drains in order
        repeat (10) mem_cycle(0, 1, 0, 0);
        repeat (8) mem_cycle(0, 0, 0, 0);

        // redirect while a request is outstanding, ack arrives later and is dropped
        next_lat = 3;
        found    = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            mem_cycle(0, mq.size() != 0, 0, 0);
            if (last_req && mq.size() != 0) found = 1'b1;
        end
        chk("wait_req_timeout", {31'b0, found}, 32'd1);
        mem_cycle(0, 0, 1, 32'h0000_0103);
        next_lat = 0;
        repeat (8) mem_cycle(0, 0, 0, 0);

        // redirect coinciding with ack under stall
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pend && lat == 0 && mq.size() != 0) found = 1'b1;
            else mem_cycle(0, mq.size() != 0, 0, 0);
        end
        chk("ack_align_timeout", {31'b0, found}, 32'd1);
        mem_cycle(0, 1, 1, 32'h0000_0200);
        repeat (6) mem_cycle(0, 0, 0, 0);

        // address wrap at the top of the space
        mem_cycle(0, 0, 1, 32'hFFFF_FFFE);
        repeat (10) mem_cycle(0, 0, 0, 0);

        // reset with a request outstanding, stray ack right after reset
        next_lat = 3;
        found    = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            mem_cycle(0, 0, 0, 0);
            if (last_req) found = 1'b1;
        end
        chk("rst_wait_timeout", {31'b0, found}, 32'd1);
        repeat (2) mem_cycle(1, 0, 0, 0);
        pend     = 1'b1;
        lat      = 0;
        next_lat = 0;
        mem_cycle(0, 0, 0, 0);
        repeat (6) mem_cycle(0, 0, 0, 0);

        // random traffic
        repeat (400) begin
            next_lat = $urandom_range(0, 3);
            mem_cycle(0, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
